// File: rtl/axi_multi_inval_filter.sv
// axi_multi_inval_filter: snoops wide-master AW channels and turns every
// accepted write burst into a stream of line-aligned L1 invalidations.
module axi_multi_inval_filter #(
  parameter int unsigned NrPorts     = 2,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineWidth = 16,
  parameter int unsigned QueueDepth  = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              en_i,
  input  logic [NrPorts-1:0]                aw_valid_i,
  output logic [NrPorts-1:0]                aw_ready_o,
  input  logic [NrPorts-1:0][AddrWidth-1:0] aw_addr_i,
  input  logic [NrPorts-1:0][7:0]           aw_len_i,
  input  logic [NrPorts-1:0][2:0]           aw_size_i,
  input  logic [NrPorts-1:0][1:0]           aw_burst_i,
  output logic [NrPorts-1:0]                aw_valid_o,
  input  logic [NrPorts-1:0]                aw_ready_i,
  output logic [AddrWidth-1:0]              inval_addr_o,
  output logic                              inval_valid_o,
  input  logic                              inval_ready_i,
  output logic                              busy_o
);

  localparam int unsigned LineShift = $clog2(L1LineWidth);
  localparam int unsigned LineW     = AddrWidth - LineShift;
  localparam int unsigned CntW      = $clog2(256 * 128 / L1LineWidth + 2);
  localparam int unsigned PtrW      = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam int unsigned QPtrW     = $clog2(QueueDepth);
  localparam int unsigned QCntW     = $clog2(QueueDepth + 1);
  localparam int unsigned OccW      = $clog2(QueueDepth + 2);

  typedef enum logic {IDLE, ISSUE} state_e;

  typedef struct packed {
    logic [LineW-1:0] line;
    logic [CntW-1:0]  cnt;
  } desc_t;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] cur_addr_q, cur_addr_d;
  logic [CntW-1:0]      cur_cnt_q, cur_cnt_d;
  logic [PtrW-1:0]      rr_q, rr_d;
  logic [PtrW-1:0]      lock_idx_q, lock_idx_d;
  logic                 lock_q, lock_d;
  logic [QPtrW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [QCntW-1:0]     qcnt_q, qcnt_d;
  desc_t                mem_q [QueueDepth];

  logic [PtrW-1:0]      sel, cand;
  logic                 sel_vld;
  logic [NrPorts-1:0]   grant, accept, hs;
  logic                 full, push, take, bypass, pop, wr;
  logic [OccW-1:0]      occ;
  logic [AddrWidth-1:0] addr, bytes, lines_w;
  desc_t                push_desc, head;

  function automatic logic [QPtrW-1:0] inc(input logic [QPtrW-1:0] p);
    return (p == QPtrW'(QueueDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // A locked port keeps its grant until it handshakes or drops valid.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    cand    = '0;
    if (lock_q && aw_valid_i[lock_idx_q]) begin
      sel     = lock_idx_q;
      sel_vld = 1'b1;
    end else begin
      for (int i = 0; i < NrPorts; i++) begin
        cand = PtrW'((int'(rr_q) + i) % NrPorts);
        if (!sel_vld && aw_valid_i[cand]) begin
          sel     = cand;
          sel_vld = 1'b1;
        end
      end
    end
  end

  assign occ  = OccW'(qcnt_q) + OccW'(inval_valid_o);
  assign full = occ >= OccW'(QueueDepth);

  always_comb begin
    grant      = '0;
    grant[sel] = sel_vld & en_i;
    accept     = en_i ? (grant & {NrPorts{~full}}) : '1;
  end

  assign aw_valid_o = aw_valid_i & accept;
  assign aw_ready_o = aw_ready_i & accept;
  assign hs         = aw_valid_o & aw_ready_i;
  assign push       = en_i & (|hs);

  always_comb begin
    addr           = aw_addr_i[sel];
    bytes          = (AddrWidth'(aw_len_i[sel]) + AddrWidth'(1))
                     << aw_size_i[sel];
    lines_w        = bytes >> LineShift;
    push_desc.line = LineW'(addr >> LineShift);
    push_desc.cnt  = CntW'(1);
    case (aw_burst_i[sel])
      2'b00: ;
      2'b10: begin
        push_desc.line = LineW'((addr & ~(bytes - AddrWidth'(1)))
                         >> LineShift);
        push_desc.cnt  = (lines_w == '0) ? CntW'(1) : CntW'(lines_w);
      end
      default: begin
        push_desc.cnt = CntW'(LineW'((addr + bytes - AddrWidth'(1))
                        >> LineShift) - push_desc.line + LineW'(1));
      end
    endcase
  end

  always_comb begin
    rr_d       = rr_q;
    lock_d     = 1'b0;
    lock_idx_d = lock_idx_q;
    if (push) begin
      rr_d = (sel == PtrW'(NrPorts - 1)) ? '0 : sel + 1'b1;
    end else if (en_i && sel_vld) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end
  end

  // An idle block with an empty queue takes a fresh descriptor directly.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cur_cnt_d  = cur_cnt_q;
    take       = 1'b0;
    case (state_q)
      IDLE: take = (qcnt_q != '0) || push;
      ISSUE: begin
        if (inval_ready_i) begin
          if (cur_cnt_q == CntW'(1)) begin
            if (qcnt_q != '0) take = 1'b1;
            else state_d = IDLE;
          end else begin
            cur_addr_d = cur_addr_q + AddrWidth'(L1LineWidth);
            cur_cnt_d  = cur_cnt_q - CntW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    bypass = take && (qcnt_q == '0);
    pop    = take && !bypass;
    wr     = push && !bypass;
    head   = bypass ? push_desc : mem_q[rd_q];
    if (take) begin
      state_d    = ISSUE;
      cur_addr_d = {head.line, {LineShift{1'b0}}};
      cur_cnt_d  = head.cnt;
    end
    rd_d   = pop ? inc(rd_q) : rd_q;
    wr_d   = wr ? inc(wr_q) : wr_q;
    qcnt_d = qcnt_q + QCntW'(wr) - QCntW'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      cur_cnt_q  <= '0;
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      qcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cur_cnt_q  <= cur_cnt_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      qcnt_q     <= qcnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_q] <= push_desc;
  end

  assign inval_valid_o = (state_q == ISSUE);
  assign inval_addr_o  = cur_addr_q & ~AddrWidth'(L1LineWidth - 1);
  assign busy_o        = (qcnt_q != '0) | inval_valid_o;

endmodule

// File: tb/tb_axi_multi_inval_filter.sv
// tb_axi_multi_inval_filter: directed and random AW traffic checked against
// a descriptor/line-list reference model of the invalidation filter.
module tb_axi_multi_inval_filter;
  localparam int N  = 2;
  localparam int AW = 64;
  localparam int LW = 16;
  localparam int LS = 4;
  localparam int QD = 4;
  localparam logic [63:0] LMASK = 64'h0FFF_FFFF_FFFF_FFFF;

  logic                    clk = 1'b0;
  logic                    rst, en;
  logic [N-1:0]            aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
  logic [N-1:0][AW-1:0]    aw_addr;
  logic [N-1:0][7:0]       aw_len;
  logic [N-1:0][2:0]       aw_size;
  logic [N-1:0][1:0]       aw_burst;
  logic [AW-1:0]           inval_addr;
  logic                    inval_valid, inval_ready, busy;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  int          desc_q[$];
  int          rr = 0;
  bit          lk = 0;
  int          lk_p = 0;
  int          idle_run = 0;
  logic [N-1:0] last_hs;

  axi_multi_inval_filter #(
    .NrPorts(N), .AddrWidth(AW), .L1LineWidth(LW), .QueueDepth(QD)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_size_i(aw_size),
    .aw_burst_i(aw_burst), .aw_valid_o(aw_valid_o),
    .aw_ready_i(aw_ready_i), .inval_addr_o(inval_addr),
    .inval_valid_o(inval_valid), .inval_ready_i(inval_ready),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if (lk && aw_valid_i[lk_p]) return lk_p;
    for (int i = 0; i < N; i++)
      if (aw_valid_i[(rr + i) % N]) return (rr + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    desc_q.delete();
    rr = 0; lk = 0; lk_p = 0; idle_run = 0;
  endtask

  // Expand one burst into the ordered list of line addresses it touches.
  task automatic model_push(input int p);
    logic [63:0] a, b, first, n;
    a = aw_addr[p];
    b = (64'(aw_len[p]) + 64'd1) << aw_size[p];
    if (aw_burst[p] == 2'b00) begin
      first = a >> LS; n = 1;
    end else if (aw_burst[p] == 2'b10) begin
      first = (a & ~(b - 1)) >> LS;
      n = b / LW;
      if (n == 0) n = 1;
    end else begin
      first = a >> LS;
      n = ((((a + b - 1) >> LS) - first) & LMASK) + 1;
    end
    for (logic [63:0] i = 0; i < n; i++) exp_q.push_back((first + i) << LS);
    desc_q.push_back(int'(n));
  endtask

  task automatic step();
    int g;
    logic [N-1:0] acc, hs;
    @(negedge clk);
    g = pick();
    for (int p = 0; p < N; p++)
      acc[p] = en ? (g == p && desc_q.size() < QD) : 1'b1;
    chk("aw_valid_o", 64'(aw_valid_o), 64'(aw_valid_i & acc));
    chk("aw_ready_o", 64'(aw_ready_o), 64'(aw_ready_i & acc));
    chk("busy_o", 64'(busy), 64'(desc_q.size() > 0));
    if (desc_q.size() > 0 && !inval_valid) idle_run++;
    else idle_run = 0;
    chk("inval_latency", 64'(idle_run > 1), 64'(0));
    if (inval_valid) begin
      if (exp_q.size() == 0) begin
        chk("inval_spurious", 64'(inval_valid), 64'(0));
      end else begin
        chk("inval_addr", inval_addr, exp_q[0]);
        if (inval_ready) begin
          void'(exp_q.pop_front());
          desc_q[0] = desc_q[0] - 1;
          if (desc_q[0] == 0) void'(desc_q.pop_front());
        end
      end
    end
    hs = aw_valid_i & aw_ready_i & acc;
    last_hs = rst ? '0 : hs;
    if (!rst) begin
      if (en && g >= 0 && hs[g]) begin
        model_push(g); rr = (g + 1) % N; lk = 0;
      end else if (en && g >= 0) begin
        lk = 1; lk_p = g;
      end else lk = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic set_aw(input int p, input logic [63:0] a,
                        input logic [7:0] l, input logic [2:0] s,
                        input logic [1:0] b);
    aw_valid_i[p] = 1'b1;
    aw_addr[p] = a; aw_len[p] = l; aw_size[p] = s; aw_burst[p] = b;
  endtask

  task automatic rand_aw(input int p);
    logic [63:0] a;
    logic [1:0]  b;
    logic [7:0]  l, t;
    a = {$urandom(), $urandom()};
    if ($urandom_range(0, 7) == 0) a[63:8] = '1;
    b = 2'($urandom_range(0, 2));
    l = 8'($urandom_range(0, 15));
    if (b == 2'b10) begin
      t = 8'($urandom_range(0, 3));
      l = (8'd2 << t) - 8'd1;
    end
    set_aw(p, a, l, 3'($urandom_range(0, 4)), b);
  endtask

  task automatic drain();
    aw_valid_i = '0;
    inval_ready = 1'b1;
    for (int i = 0; i < 3000 && desc_q.size() > 0; i++) step();
    chk("drain_timeout", 64'(desc_q.size()), 64'(0));
    chk("drain_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; aw_valid_i = '0; aw_ready_i = '1;
    aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
    inval_ready = 1'b1; last_hs = '0;
    #1;
    chk("rst_inval_valid", 64'(inval_valid), 64'(0));
    chk("rst_inval_addr", inval_addr, 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_aw_ready_en", 64'(aw_ready_o), 64'(0));
    en = 1'b0; #1;
    chk("rst_aw_ready_dis", 64'(aw_ready_o), 64'(2'b11));
    en = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    // INCR at 0x1008, 32 bytes -> three lines on consecutive cycles
    set_aw(0, 64'h1008, 8'd3, 3'd3, 2'b01);
    step();
    aw_valid_i = '0;
    chk("incr_v0", 64'(inval_valid), 64'(1));
    chk("incr_a0", inval_addr, 64'h1000);
    step();
    chk("incr_a1", inval_addr, 64'h1010);
    step();
    chk("incr_a2", inval_addr, 64'h1020);
    step();
    chk("incr_end", 64'(inval_valid), 64'(0));

    // bring round-robin pointer back to port 0, then collide both ports
    set_aw(1, 64'h4800, 8'd0, 3'd4, 2'b00);
    step();
    aw_valid_i = '0;
    drain();
    set_aw(0, 64'h4000, 8'd0, 3'd4, 2'b01);
    set_aw(1, 64'h5000, 8'd0, 3'd4, 2'b01);
    #1;
    chk("rr_first_p0", 64'(aw_valid_o), 64'(2'b01));
    step();
    aw_valid_i[0] = 1'b0;
    #1;
    chk("rr_then_p1", 64'(aw_valid_o), 64'(2'b10));
    chk("rr_inval_p0", inval_addr, 64'h4000);
    step();
    aw_valid_i[1] = 1'b0;
    drain();

    // queue fills with four pending descriptors
    inval_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_aw(0, 64'h6000 + 64'(16 * k), 8'd0, 3'd4, 2'b01);
      step();
      aw_valid_i[0] = 1'b0;
    end
    set_aw(0, 64'h6040, 8'd0, 3'd4, 2'b01);
    #1;
    chk("full_block0", 64'(aw_ready_o), 64'(0));
    step(); step();
    chk("full_block1", 64'(aw_ready_o), 64'(0));
    chk("full_hold_addr", inval_addr, 64'h6000);
    inval_ready = 1'b1;
    #1;
    chk("full_pop_cycle", 64'(aw_ready_o), 64'(0));
    step();
    chk("full_release", 64'(aw_ready_o), 64'(2'b01));
    step();
    aw_valid_i = aw_valid_i & ~last_hs;
    drain();

    // coherence disabled: pass-through only
    en = 1'b0;
    set_aw(0, 64'h7000, 8'd15, 3'd4, 2'b01);
    #1;
    chk("dis_valid_fwd", 64'(aw_valid_o), 64'(2'b01));
    chk("dis_ready_fwd", 64'(aw_ready_o), 64'(2'b11));
    step();
    aw_valid_i = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("dis_no_inval", 64'(inval_valid), 64'(0));
      chk("dis_no_busy", 64'(busy), 64'(0));
    end
    en = 1'b1;

    // FIXED then WRAP
    set_aw(0, 64'h2000, 8'd15, 3'd3, 2'b00);
    step();
    aw_valid_i = '0;
    chk("fixed_a0", inval_addr, 64'h2000);
    step();
    chk("fixed_end", 64'(inval_valid), 64'(0));
    set_aw(1, 64'h3028, 8'd3, 3'd3, 2'b10);
    step();
    aw_valid_i = '0;
    chk("wrap_a0", inval_addr, 64'h3020);
    step();
    chk("wrap_a1", inval_addr, 64'h3030);
    step();
    chk("wrap_end", 64'(inval_valid), 64'(0));

    // reset in the middle of a three-line burst
    set_aw(0, 64'h8000, 8'd2, 3'd4, 2'b01);
    step();
    aw_valid_i = '0;
    chk("mid_a0", inval_addr, 64'h8000);
    step();
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_valid", 64'(inval_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_addr", inval_addr, 64'(0));
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("mid_no_inval", 64'(inval_valid), 64'(0));
    end

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < N; p++)
        if (!aw_valid_i[p] && $urandom_range(0, 2) == 0) rand_aw(p);
      aw_ready_i = N'($urandom());
      inval_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) == 0) en = ~en;
      step();
      aw_valid_i = aw_valid_i & ~last_hs;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_multi_inval_filter.md
AXI_MULTI_INVAL_FILTER -- requirements
Module: axi_multi_inval_filter

Interface
REQ-001 SHALL have parameter NrPorts, default 2, giving the number of snooped AXI write-address (AW) ports, each from a wide (vector) master.
REQ-002 SHALL have parameter AddrWidth, default 64, giving the AXI address width.
REQ-003 SHALL have parameter L1LineWidth, default 16, giving the L1 D-cache line size in bytes; it is a power of two, at least 8.
REQ-004 SHALL have parameter QueueDepth, default 4, giving the number of pending burst descriptors; it is at least 2.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state is on the rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port en_i, input, 1 bit: coherence enable.
REQ-008 SHALL have port aw_valid_i, input, NrPorts bits: AW valid from each upstream master.
REQ-009 SHALL have port aw_ready_o, output, NrPorts bits: AW ready to each upstream master.
REQ-010 SHALL have port aw_addr_i, input, NrPorts x AddrWidth bits: AW address per port.
REQ-011 SHALL have port aw_len_i, input, NrPorts x 8 bits: AXI burst length minus one.
REQ-012 SHALL have port aw_size_i, input, NrPorts x 3 bits: AXI beat size as log2 of bytes.
REQ-013 SHALL have port aw_burst_i, input, NrPorts x 2 bits: AXI burst type (FIXED, INCR or WRAP).
REQ-014 SHALL have port aw_valid_o, output, NrPorts bits: AW valid forwarded downstream.
REQ-015 SHALL have port aw_ready_i, input, NrPorts bits: AW ready from downstream.
REQ-016 SHALL have port inval_addr_o, output, AddrWidth bits: line-aligned invalidation address.
REQ-017 SHALL have port inval_valid_o, output, 1 bit: invalidation request valid.
REQ-018 SHALL have port inval_ready_i, input, 1 bit: the cache accepts the invalidation.
REQ-019 SHALL have port busy_o, output, 1 bit: high when the queue is non-empty or an issue is in progress.

Function
REQ-020 SHALL generate accept[p] combinationally, drive aw_valid_o[p] = aw_valid_i[p] & accept[p], and drive aw_ready_o[p] = aw_ready_i[p] & accept[p].
REQ-021 SHALL, when en_i=0, set accept to all ones, push nothing and leave AW traffic untouched.
REQ-022 SHALL, when en_i=1, set accept[p] = grant[p] & ~queue_full, where grant is a one-hot round-robin pick among asserted aw_valid_i.
REQ-023 SHALL start the round-robin search at port rr_ptr and, on a forwarded handshake of port p, set rr_ptr to (p+1) mod NrPorts; otherwise rr_ptr holds.
REQ-024 SHALL keep a granted port's grant stable while its aw_valid_i stays high and no handshake has occurred.
REQ-025 SHALL, on a forwarded handshake (aw_valid_o & aw_ready_i) with en_i=1, push exactly one descriptor {line_addr, n_lines} that same cycle.
REQ-026 SHALL compute descriptors with B = (len+1) << size and line = addr >> log2(L1LineWidth).
REQ-027 SHALL use, for FIXED bursts, the line of addr with n_lines = 1.
REQ-028 SHALL use, for INCR bursts, the line of addr with n_lines = line(addr+B-1) - line(addr) + 1.
REQ-029 SHALL use, for WRAP bursts, the line of addr aligned down to B, with n_lines = max(1, B / L1LineWidth).
REQ-030 SHALL use address arithmetic modulo 2^AddrWidth and size the n_lines counter to hold 256*128/L1LineWidth.
REQ-031 SHALL implement the issue FSM with IDLE and ISSUE states.
REQ-032 SHALL move from IDLE to ISSUE when the queue is non-empty, popping the head into cur_addr and cur_cnt.
REQ-033 SHALL, in ISSUE, drive inval_valid_o=1 and inval_addr_o = cur_addr with the low log2(L1LineWidth) bits zero.
REQ-034 SHALL, in ISSUE on an inval_valid_o & inval_ready_i handshake, add L1LineWidth to cur_addr and decrement cur_cnt.
REQ-035 SHALL, when cur_cnt=1 at a handshake, pop the next descriptor in the same cycle if the queue is non-empty, else go to IDLE.
REQ-036 SHALL hold inval_addr_o stable while inval_valid_o=1 and inval_ready_i=0.
REQ-037 SHALL issue the first invalidation of a descriptor pushed into an empty idle block in the cycle after the push, a latency of one.
REQ-038 SHALL, when full, allow a push only if a pop occurs the same cycle; queue_full deasserts accept regardless of a same-cycle pop.
REQ-039 SHALL continue to drain queued and in-progress descriptors after en_i falls.
REQ-040 SHALL keep FIFO order for descriptors and ascending line order within a descriptor, including wrap past address 2^AddrWidth-1 to 0.

Reset
REQ-041 SHALL, while rst_i=1, empty the queue, set the FSM to IDLE, set rr_ptr=0, cur_addr=0 and cur_cnt=0.
REQ-042 SHALL, while rst_i=1, drive inval_valid_o=0, inval_addr_o=0 and busy_o=0, with aw_ready_o and aw_valid_o following REQ-020 on the empty queue.
REQ-043 SHALL, on reset mid-operation, drop all pending invalidations without issuing them after release.

Verification
REQ-044 SHALL verify: en_i=1, INCR at 0x1008, len=3, size=3, inval_ready_i=1 -> invalidations at 0x1000, 0x1010, 0x1020 on three consecutive cycles starting one cycle after the AW handshake.
REQ-045 SHALL verify: both ports valid in the same cycle with rr_ptr=0 -> port 0 is forwarded at cycle n and port 1 at n+1, with descriptors issued in that order.
REQ-046 SHALL verify: inval_ready_i=0 and four single-line AWs accepted -> the fifth AW sees aw_ready_o=0 until the first inval handshake, then is accepted.
REQ-047 SHALL verify: en_i=0 and an INCR of 256 bytes -> the AW is forwarded, inval_valid_o stays 0 and busy_o stays 0.
REQ-048 SHALL verify: FIXED at 0x2000, len=15 -> a single invalidation at 0x2000; WRAP at 0x3028, len=3, size=3 -> invalidations at 0x3020 and 0x3030.
REQ-049 SHALL verify: rst_i pulsed after the first of three invalidations -> inval_valid_o=0 from the reset edge, busy_o=0, and no further invalidations.
